// File: rtl/decode_stage_pkg.sv
// Shared definitions for the RV32I decode stage: control bundle, held-entry
// payload, opcode constants, skid-buffer state encoding and the ALU sign rule.
package decode_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic a;
    logic sign;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } control_signals_t;

  typedef struct packed {
    logic [2:0]       func3;
    control_signals_t cs;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [4:0]       rd;
    logic [31:0]      store_data;
    logic [31:0]      br_target;
  } decode_entry_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] SKID_EMPTY = 2'd0;
  localparam logic [1:0] SKID_ONE   = 2'd1;
  localparam logic [1:0] SKID_TWO   = 2'd2;

  // Register-register ops take instr[30] as SUB/SRA selector on 000 and 101;
  // immediate ops only on 101, since ADDI has no subtract form. SLT/SLTU
  // always need a signed-style subtract compare.
  function automatic logic alu_sign(input logic [2:0] f3, input logic bit30,
                                    input logic is_reg);
    logic s;
    case (f3)
      3'b000:  s = is_reg & bit30;
      3'b101:  s = bit30;
      3'b010:  s = 1'b1;
      3'b011:  s = 1'b1;
      default: s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: picks the RV32I immediate format from the opcode and
// returns it sign-extended to 32 bits. Opcodes without an immediate give 0.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  // Select the immediate format that belongs to the opcode
  always_comb begin
    imm_o = 32'd0;
    case (instr_i[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_o = imm_i;
      OPC_STORE:                      imm_o = imm_s;
      OPC_BRANCH:                     imm_o = imm_b;
      OPC_LUI, OPC_AUIPC:             imm_o = imm_u;
      OPC_JAL:                        imm_o = imm_j;
      default:                        imm_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage between fetch and execute, with a 2-entry
// skid buffer so in_ready is a flop rather than a path from out_ready.
// Optional build macro DECODE_ILLEGAL_TRAP_EN adds an 'illegal' output flag
// carried with each held entry.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       func3,
  output control_signals_t cs,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  store_data,
  output logic [XLEN-1:0]  br_target
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  logic [6:0]    opcode;
  logic [2:0]    f3;
  logic [6:0]    f7;
  logic [31:0]   rs1_val;
  logic [31:0]   rs2_val;
  logic [31:0]   imm;
  logic          is_illegal;
  decode_entry_t dec;

  logic [1:0]    state_q, state_d;
  logic          in_ready_q, in_ready_d;
  decode_entry_t entry0_q, entry0_d;
  decode_entry_t entry1_q, entry1_d;
  logic          accept;
  logic          load0_in;
  logic          load0_promote;
  logic          load1_in;

  assign opcode   = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign f7       = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign rs1_val  = (rs1_addr == 5'd0) ? 32'd0 : rs1_data;
  assign rs2_val  = (rs2_addr == 5'd0) ? 32'd0 : rs2_data;

  decode_stage_imm_gen u_imm_gen (
    .instr_i (in_instr),
    .imm_o   (imm)
  );

  // Flag encodings we do not implement: unknown opcodes and bad func7 fields
  always_comb begin
    is_illegal = 1'b0;
    case (opcode)
      OPC_OP: is_illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
      OPC_OP_IMM: begin
        if (f3 == 3'b001)
          is_illegal = (f7 != F7_BASE);
        else if (f3 == 3'b101)
          is_illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
      end
      OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: is_illegal = 1'b0;
      default: is_illegal = 1'b1;
    endcase
  end

  // Build the ALU operand/control payload for the offered instruction;
  // illegal encodings leave the all-zero NOP payload
  always_comb begin
    dec = '0;
    if (!is_illegal) begin
      case (opcode)
        OPC_OP: begin
          dec.func3        = f3;
          dec.cs.a         = 1'b1;
          dec.cs.sign      = alu_sign(f3, in_instr[30], 1'b1);
          dec.cs.reg_write = 1'b1;
          dec.alu_a        = rs1_val;
          dec.alu_b        = rs2_val;
        end
        OPC_OP_IMM: begin
          dec.func3        = f3;
          dec.cs.a         = 1'b1;
          dec.cs.sign      = alu_sign(f3, in_instr[30], 1'b0);
          dec.cs.reg_write = 1'b1;
          dec.alu_a        = rs1_val;
          if ((f3 == 3'b001) || (f3 == 3'b101))
            dec.alu_b = {27'd0, in_instr[24:20]};
          else
            dec.alu_b = imm;
        end
        OPC_LOAD: begin
          dec.func3        = f3;
          dec.cs.mem_read  = 1'b1;
          dec.cs.reg_write = 1'b1;
          dec.alu_a        = rs1_val;
          dec.alu_b        = imm;
        end
        OPC_STORE: begin
          dec.func3        = f3;
          dec.cs.mem_write = 1'b1;
          dec.alu_a        = rs1_val;
          dec.alu_b        = imm;
          dec.store_data   = rs2_val;
        end
        OPC_BRANCH: begin
          dec.func3     = f3;
          dec.cs.sign   = 1'b1;
          dec.cs.branch = 1'b1;
          dec.alu_a     = rs1_val;
          dec.alu_b     = rs2_val;
          dec.br_target = in_pc + imm;
        end
        OPC_LUI: begin
          dec.cs.reg_write = 1'b1;
          dec.alu_b        = imm;
        end
        OPC_AUIPC: begin
          dec.cs.reg_write = 1'b1;
          dec.alu_a        = in_pc;
          dec.alu_b        = imm;
        end
        OPC_JAL: begin
          dec.cs.jump      = 1'b1;
          dec.cs.reg_write = 1'b1;
          dec.alu_a        = in_pc;
          dec.alu_b        = 32'd4;
          dec.br_target    = in_pc + imm;
        end
        OPC_JALR: begin
          dec.cs.jump      = 1'b1;
          dec.cs.reg_write = 1'b1;
          dec.alu_a        = in_pc;
          dec.alu_b        = 32'd4;
          dec.br_target    = (rs1_val + imm) & 32'hFFFF_FFFE;
        end
        default: dec = '0;
      endcase
      if (dec.cs.reg_write)
        dec.rd = in_instr[11:7];
    end
  end

  assign accept = in_valid && in_ready_q && !flush;

  // Skid FSM: decide next occupancy and which entry, if any, captures data
  always_comb begin
    state_d       = state_q;
    load0_in      = 1'b0;
    load0_promote = 1'b0;
    load1_in      = 1'b0;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            state_d  = SKID_ONE;
            load0_in = 1'b1;
          end
        end
        SKID_ONE: begin
          if (accept && out_ready) begin
            load0_in = 1'b1;
          end else if (accept) begin
            state_d  = SKID_TWO;
            load1_in = 1'b1;
          end else if (out_ready) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          if (out_ready) begin
            state_d       = SKID_ONE;
            load0_promote = 1'b1;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  // Entry payload next-state from the FSM's capture/promote decisions
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    if (load0_in)
      entry0_d = dec;
    else if (load0_promote)
      entry0_d = entry1_q;
    if (load1_in)
      entry1_d = dec;
  end

  assign in_ready_d = (state_d != SKID_TWO);

  // State, ready flag and held entries; reset empties both entries at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SKID_EMPTY;
      in_ready_q <= 1'b1;
      entry0_q   <= '0;
      entry1_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      entry0_q   <= entry0_d;
      entry1_q   <= entry1_d;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal0_q, illegal1_q;

  // Illegal flag travels with its entry exactly like the payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal0_q <= 1'b0;
      illegal1_q <= 1'b0;
    end else begin
      if (load0_in)
        illegal0_q <= is_illegal;
      else if (load0_promote)
        illegal0_q <= illegal1_q;
      if (load1_in)
        illegal1_q <= is_illegal;
    end
  end

  assign illegal = illegal0_q;
`endif

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != SKID_EMPTY);
  assign func3      = entry0_q.func3;
  assign cs         = entry0_q.cs;
  assign alu_a      = entry0_q.alu_a;
  assign alu_b      = entry0_q.alu_b;
  assign rd         = entry0_q.rd;
  assign store_data = entry0_q.store_data;
  assign br_target  = entry0_q.br_target;

endmodule
